// File: rtl/neural_frame_pkg.sv
// neural_frame_pkg: shared constants, FSM state type and CRC-16-CCITT helper
//   for the neural frame packer.
//   Contents: MAGIC_DEFAULT, HDR_WORDS/TS_WORDS/TAIL_WORDS, CRC_POLY/CRC_INIT,
//   state_t, crc16_w16().
package neural_frame_pkg;
  localparam logic [63:0] MAGIC_DEFAULT = 64'hC691_1999_2702_1942;
  localparam int HDR_WORDS = 4;
  localparam int TS_WORDS = 2;
  localparam int TAIL_WORDS = 2;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  typedef enum logic [2:0] {IDLE, HDR, TS, DATA, TAIL} state_t;
  // One 16-bit word folded into the CRC, MSB first.
  function automatic logic [15:0] crc16_w16(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? CRC_POLY : 16'h0);
    return r;
  endfunction
endpackage

// File: rtl/crc16_ccitt_w16.sv
// crc16_ccitt_w16: single-cycle 16-bit parallel CRC-16-CCITT accumulator.
//   dataclk, fifo_reset : clock, async active-high reset
//   clr_i               : restart from CRC_INIT (combined with en_i, folds data_i into the fresh seed)
//   en_i, data_i        : fold data_i into the running CRC
//   crc_o               : current CRC value
module crc16_ccitt_w16
  import neural_frame_pkg::*;
(
  input  logic        dataclk,
  input  logic        fifo_reset,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] data_i,
  output logic [15:0] crc_o
);
  logic [15:0] crc_q, crc_d, seed;
  always_comb begin
    seed = clr_i ? CRC_INIT : crc_q;
    crc_d = en_i ? crc16_w16(seed, data_i) : seed;
  end
  always_ff @(posedge dataclk or posedge fifo_reset)
    if (fifo_reset) crc_q <= CRC_INIT;
    else crc_q <= crc_d;
  assign crc_o = crc_q;
endmodule

// File: rtl/neural_frame_packer.sv
// neural_frame_packer: frames channel samples into a 16-bit word stream for the Xillybus FIFO.
//   dataclk, fifo_reset      : clock, async active-high reset
//   frame_start              : one pulse per sample period
//   fifo_overflow            : downstream overflow, frames are dropped while high
//   ch_addr / ch_rdata       : sample-buffer port, synchronous read with 1-cycle latency
//   FIFO_DATA_STREAM(_WEN)   : registered framed word and its valid
//   busy, frame_dropped      : frame in progress, one-cycle drop pulse
//   timestamp                : frame_start counter
//   Define NEURAL_FRAME_CRC_EN to append a CRC word and a pad word to each frame.
module neural_frame_packer
  import neural_frame_pkg::*;
#(
  parameter int          NUM_CH = 32,
  parameter logic [63:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic        dataclk,
  input  logic        fifo_reset,
  input  logic        frame_start,
  input  logic        fifo_overflow,
  output logic [7:0]  ch_addr,
  input  logic [15:0] ch_rdata,
  output logic [15:0] FIFO_DATA_STREAM,
  output logic        FIFO_DATA_STREAM_WEN,
  output logic        busy,
  output logic        frame_dropped,
  output logic [31:0] timestamp
);
  localparam int DSTART = HDR_WORDS + TS_WORDS;
  localparam int DEND = DSTART + NUM_CH;
`ifdef NEURAL_FRAME_CRC_EN
  localparam int LEN = DEND + TAIL_WORDS;
`else
  localparam int LEN = DEND;
`endif
  state_t state_q, state_d;
  logic [8:0] idx_q, n_d;
  logic [31:0] ts_q, ts_d, fts_q;
  logic [15:0] word_q, word_d, tail_w;
  logic [7:0] addr_q, addr_d;
  logic wen_q, drop_q, last, accept, go, rd;
  assign last = idx_q == 9'(LEN - 1);
  // A new frame may start on the edge that retires the last word, so frames can abut.
  assign accept = frame_start && !fifo_overflow && (state_q == IDLE || last);
  assign go = accept || (state_q != IDLE && !last);
  assign n_d = accept ? 9'd0 : idx_q + 9'd1;
  // The address leads its data word by two cycles: one for the buffer read, one for the output register.
  assign rd = go && n_d >= 9'(DSTART - 2) && n_d < 9'(DEND - 2);
`ifdef NEURAL_FRAME_CRC_EN
  logic [15:0] crc;
  crc16_ccitt_w16 u_crc (
    .dataclk(dataclk),
    .fifo_reset(fifo_reset),
    .clr_i(accept),
    .en_i(go && n_d < 9'(DEND)),
    .data_i(word_d),
    .crc_o(crc)
  );
  assign tail_w = n_d == 9'(DEND) ? crc : 16'h0;
`else
  assign tail_w = 16'h0;
`endif
  always_comb begin
    state_d = !go ? IDLE : n_d < 9'(HDR_WORDS) ? HDR : n_d < 9'(DSTART) ? TS : n_d < 9'(DEND) ? DATA : TAIL;
    word_d = n_d < 9'(HDR_WORDS) ? MAGIC[{n_d[1:0], 4'b0} +: 16] :
             n_d == 9'(HDR_WORDS) ? fts_q[15:0] :
             n_d < 9'(DSTART) ? fts_q[31:16] :
             n_d < 9'(DEND) ? ch_rdata : tail_w;
    addr_d = rd ? 8'(n_d - 9'(DSTART - 2)) : addr_q;
    ts_d = ts_q + 32'(frame_start);
  end
  always_ff @(posedge dataclk or posedge fifo_reset)
    if (fifo_reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      ts_q <= '0;
      fts_q <= '0;
      word_q <= '0;
      wen_q <= 1'b0;
      drop_q <= 1'b0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= go ? n_d : idx_q;
      ts_q <= ts_d;
      fts_q <= accept ? ts_q : fts_q;
      word_q <= go ? word_d : word_q;
      wen_q <= go;
      drop_q <= frame_start && !accept;
      addr_q <= addr_d;
    end
  assign FIFO_DATA_STREAM = word_q;
  assign FIFO_DATA_STREAM_WEN = wen_q;
  assign busy = state_q != IDLE;
  assign frame_dropped = drop_q;
  assign timestamp = ts_q;
  assign ch_addr = addr_q;
endmodule

// File: tb/tb_neural_frame_packer.sv
// tb_neural_frame_packer: directed self-checking bench for neural_frame_packer with NUM_CH=4.
module tb_neural_frame_packer;
  localparam int NC = 4;
`ifdef NEURAL_FRAME_CRC_EN
  localparam int LEN = NC + 8;
`else
  localparam int LEN = NC + 6;
`endif
  logic dataclk = 1'b0, fifo_reset = 1'b1, frame_start = 1'b0, fifo_overflow = 1'b0;
  logic [7:0] ch_addr;
  logic [15:0] ch_rdata, FIFO_DATA_STREAM;
  logic FIFO_DATA_STREAM_WEN, busy, frame_dropped;
  logic [31:0] timestamp;
  int n_tests = 0, n_fail = 0, drops = 0, runs = 0;
  logic prev_wen = 1'b0;
  logic [15:0] cap[$];
  typedef struct {
    string name;
    logic ov;
    logic [31:0] ts;
    logic drop;
  } vec_t;
  vec_t vecs[4];
  int c0, c1, d0, r0;

  neural_frame_packer #(.NUM_CH(NC)) dut (
    .dataclk(dataclk),
    .fifo_reset(fifo_reset),
    .frame_start(frame_start),
    .fifo_overflow(fifo_overflow),
    .ch_addr(ch_addr),
    .ch_rdata(ch_rdata),
    .FIFO_DATA_STREAM(FIFO_DATA_STREAM),
    .FIFO_DATA_STREAM_WEN(FIFO_DATA_STREAM_WEN),
    .busy(busy),
    .frame_dropped(frame_dropped),
    .timestamp(timestamp)
  );

  always #5 dataclk = ~dataclk;
  always @(posedge dataclk) ch_rdata <= 16'h1000 + {8'h00, ch_addr};
  always @(negedge dataclk) begin
    if (FIFO_DATA_STREAM_WEN) cap.push_back(FIFO_DATA_STREAM);
    if (FIFO_DATA_STREAM_WEN && !prev_wen) runs++;
    if (frame_dropped) drops++;
    prev_wen = FIFO_DATA_STREAM_WEN;
  end

  function automatic logic [15:0] data_word(int i, logic [31:0] ts);
    logic [15:0] mw[4];
    mw = '{16'h1942, 16'h2702, 16'h1999, 16'hC691};
    if (i < 4) return mw[i];
    if (i == 4) return ts[15:0];
    if (i == 5) return ts[31:16];
    return 16'h1000 + 16'(i - 6);
  endfunction

  function automatic logic [15:0] crc_ref(logic [31:0] ts);
    logic [15:0] c, w;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < 6 + NC; i++) begin
      w = data_word(i, ts);
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ w[b];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] exp_word(int i, logic [31:0] ts);
    if (i < 6 + NC) return data_word(i, ts);
    if (i == 6 + NC) return crc_ref(ts);
    return 16'h0000;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge dataclk);
    #1;
  endtask

  task automatic start(logic ov);
    frame_start = 1'b1;
    fifo_overflow = ov;
    tick(1);
    frame_start = 1'b0;
    fifo_overflow = 1'b0;
  endtask

  task automatic do_reset();
    fifo_reset = 1'b1;
    tick(2);
    fifo_reset = 1'b0;
    tick(2);
  endtask

  task automatic chk_frame(string nm, int base, logic [31:0] ts);
    for (int i = 0; i < LEN; i++)
      chk($sformatf("%s_w%0d", nm, i), (base + i < cap.size()) ? {16'h0, cap[base + i]} : 32'hDEAD_BEEF,
          {16'h0, exp_word(i, ts)});
  endtask

  initial begin
    vecs[0] = '{"single", 1'b0, 32'd0, 1'b0};
    vecs[1] = '{"ovf", 1'b1, 32'd1, 1'b1};
    vecs[2] = '{"after_ovf", 1'b0, 32'd2, 1'b0};
    vecs[3] = '{"next", 1'b0, 32'd3, 1'b0};
    tick(2);
    chk("rst_wen", {31'h0, FIFO_DATA_STREAM_WEN}, 32'h0);
    chk("rst_data", {16'h0, FIFO_DATA_STREAM}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_drop", {31'h0, frame_dropped}, 32'h0);
    chk("rst_ts", timestamp, 32'h0);
    chk("rst_addr", {24'h0, ch_addr}, 32'h0);
    fifo_reset = 1'b0;
    tick(2);
    foreach (vecs[v]) begin
      c0 = cap.size();
      d0 = drops;
      start(vecs[v].ov);
      chk({vecs[v].name, "_drop_pulse"}, {31'h0, frame_dropped}, {31'h0, vecs[v].drop});
      chk({vecs[v].name, "_wen0"}, {31'h0, FIFO_DATA_STREAM_WEN}, {31'h0, !vecs[v].drop});
      chk({vecs[v].name, "_busy"}, {31'h0, busy}, {31'h0, !vecs[v].drop});
      tick(LEN + 1);
      chk({vecs[v].name, "_count"}, 32'(cap.size() - c0), vecs[v].drop ? 32'd0 : 32'(LEN));
      chk({vecs[v].name, "_drops"}, 32'(drops - d0), {31'h0, vecs[v].drop});
      chk({vecs[v].name, "_ts_after"}, timestamp, vecs[v].ts + 32'd1);
      chk({vecs[v].name, "_idle"}, {31'h0, busy}, 32'h0);
      if (!vecs[v].drop) begin
        chk_frame(vecs[v].name, c0, vecs[v].ts);
        chk({vecs[v].name, "_addr_hold"}, {24'h0, ch_addr}, 32'(NC - 1));
      end
    end

    c0 = cap.size();
    r0 = runs;
    d0 = drops;
    start(1'b0);
    tick(LEN - 1);
    chk("b2b_last_busy", {31'h0, busy}, 32'h1);
    start(1'b0);
    chk("b2b_wen", {31'h0, FIFO_DATA_STREAM_WEN}, 32'h1);
    chk("b2b_first", {16'h0, FIFO_DATA_STREAM}, 32'h1942);
    tick(LEN + 1);
    chk("b2b_count", 32'(cap.size() - c0), 32'(2 * LEN));
    chk("b2b_runs", 32'(runs - r0), 32'd1);
    chk("b2b_drops", 32'(drops - d0), 32'd0);
    chk_frame("b2b_f1", c0, 32'd4);
    chk_frame("b2b_f2", c0 + LEN, 32'd5);

    do_reset();
    c0 = cap.size();
    r0 = runs;
    d0 = drops;
    start(1'b0);
    tick(7);
    start(1'b0);
    chk("busy_drop_pulse", {31'h0, frame_dropped}, 32'h1);
    tick(LEN);
    start(1'b0);
    tick(LEN + 1);
    chk("busy_drops", 32'(drops - d0), 32'd1);
    chk("busy_runs", 32'(runs - r0), 32'd2);
    chk("busy_count", 32'(cap.size() - c0), 32'(2 * LEN));
    chk("busy_ts", timestamp, 32'd3);
    chk_frame("busy_f1", c0, 32'd0);
    chk_frame("busy_f2", c0 + LEN, 32'd2);

    do_reset();
    c0 = cap.size();
    start(1'b1);
    chk("ovf_wen", {31'h0, FIFO_DATA_STREAM_WEN}, 32'h0);
    chk("ovf_drop", {31'h0, frame_dropped}, 32'h1);
    tick(LEN);
    chk("ovf_count", 32'(cap.size() - c0), 32'd0);
    chk("ovf_ts", timestamp, 32'd1);
    do_reset();
    chk("ovf_rst_ts", timestamp, 32'd0);
    c0 = cap.size();
    start(1'b0);
    tick(LEN + 1);
    chk("ovf_next_count", 32'(cap.size() - c0), 32'(LEN));
    chk_frame("ovf_next", c0, 32'd0);

    c0 = cap.size();
    start(1'b0);
    tick(8);
    chk("mid_wen", {31'h0, FIFO_DATA_STREAM_WEN}, 32'h1);
    chk("mid_word", {16'h0, FIFO_DATA_STREAM}, 32'h1002);
    #2 fifo_reset = 1'b1;
    #1;
    chk("mid_rst_wen", {31'h0, FIFO_DATA_STREAM_WEN}, 32'h0);
    chk("mid_rst_ts", timestamp, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    tick(1);
    fifo_reset = 1'b0;
    tick(1);
    chk("mid_partial", 32'(cap.size() - c0), 32'd8);
    c1 = cap.size();
    start(1'b0);
    tick(LEN + 1);
    chk("mid_next_count", 32'(cap.size() - c1), 32'(LEN));
    chk_frame("mid_next", c1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
